conv1d_frame_ctrl: RTL and testbench

Frame-level sequencer for the streaming Conv1D core. It sits between the upstream input FIFO, the core's input/output FIFO ports and the downstream output FIFO. It owns the block-level handshake (`ap_start`/`ap_done`/`ap_idle`/`ap_ready`/`ap_continue`), admits exactly NIN input samples per frame and forwards exactly NOUT results. Between frames it holds the core in reset so every frame starts with an empty shift register and pipeline.

---
 rtl/conv1d_pkg.sv | 19 +
 rtl/conv1d_beat_gate.sv | 44 ++++
 rtl/conv1d_frame_ctrl.sv | 161 ++++++++++++++++
 tb/tb_conv1d_frame_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv1d_pkg.sv
// Shared types and default dimensions for the streaming Conv1D core and its frame controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv1d_pkg;

    localparam int DATA_W      = 8;
    localparam int KERNEL_SIZE = 32;
    localparam int NIN         = 128;
    localparam int NOUT        = NIN - KERNEL_SIZE + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } conv1d_ctrl_state_t;

endpackage

// File: rtl/conv1d_beat_gate.sv
// Counting valid/ready gate: passes beats while enabled and below LIMIT, then closes.
// Latency: combinational pass-through; the count updates on the clock after an accept.
// Backpressure: ready/valid are both forced low once LIMIT beats have been counted.
// Ports: clk/rst_n; en and clr from the sequencer; up_vld/dn_rdy raw handshake;
//        gated_vld/gated_rdy gated handshake; accept, cnt and last report progress.
module conv1d_beat_gate #(
    parameter int LIMIT        = conv1d_pkg::NIN,
    // 1: a beat counts on gated valid alone (the sender already honoured ready)
    parameter bit COUNT_ON_VLD = 1'b0,
    localparam int CNT_W       = $clog2(LIMIT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             up_vld,
    input  logic             dn_rdy,
    output logic             gated_vld,
    output logic             gated_rdy,
    output logic             accept,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic open_gate;

    assign open_gate = en && (cnt < CNT_W'(LIMIT));
    assign gated_vld = up_vld && open_gate;
    assign gated_rdy = dn_rdy && open_gate;
    assign accept    = COUNT_ON_VLD ? gated_vld : (gated_vld && dn_rdy);
    assign last      = accept && (cnt == CNT_W'(LIMIT - 1));

    // Saturates at LIMIT because open_gate blocks further accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/conv1d_frame_ctrl.sv
// Frame sequencer for the Conv1D core: admits NIN samples, forwards NOUT results, ap_* block handshake.
// Latency: data paths are pure wires; RUN starts CLEAR_CYCLES+1 cycles after ap_start is sampled.
// Backpressure: src/dst empty_n/full_n pass straight through to the core, gated by frame state and counts.
// Ports: ap_* block control; src_* upstream FIFO; core_in_*/core_out_*/core_rst to the core;
//        dst_* downstream FIFO; err_overflow (sticky) and frame_cnt status.
module conv1d_frame_ctrl #(
    parameter int DATA_W       = conv1d_pkg::DATA_W,
    parameter int NIN          = conv1d_pkg::NIN,
    parameter int NOUT         = conv1d_pkg::NOUT,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    input  logic              ap_continue,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [DATA_W-1:0] src_dout,
    input  logic              src_empty_n,
    output logic              src_read,
    output logic [DATA_W-1:0] core_in_dout,
    output logic              core_in_empty_n,
    input  logic              core_in_read,
    input  logic [DATA_W-1:0] core_out_din,
    input  logic              core_out_write,
    output logic              core_out_full_n,
    output logic [DATA_W-1:0] dst_din,
    output logic              dst_write,
    input  logic              dst_full_n,
    output logic              core_rst,
    output logic              err_overflow,
    output logic [15:0]       frame_cnt
);

    import conv1d_pkg::*;

    localparam int IN_W  = $clog2(NIN + 1);
    localparam int OUT_W = $clog2(NOUT + 1);
    localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);

    conv1d_ctrl_state_t state, state_nxt;

    logic [CLR_W-1:0] clr_cnt;
    logic [IN_W-1:0]  in_cnt;
    logic [OUT_W-1:0] out_cnt;
    logic             in_en, out_en;
    logic             in_last;
    logic             start_frame, drop_beat;
    logic             unused_in_rdy, unused_out_acc, unused_out_last;

    assign core_in_dout = src_dout;
    assign dst_din      = core_out_din;
    assign ap_ready     = in_last;

    // Counters are held clear for the whole time the core is in reset.
    conv1d_beat_gate #(.LIMIT(NIN), .COUNT_ON_VLD(1'b0)) u_in_gate (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .en        (in_en),
        .clr       (core_rst),
        .up_vld    (src_empty_n),
        .dn_rdy    (core_in_read),
        .gated_vld (core_in_empty_n),
        .gated_rdy (unused_in_rdy),
        .accept    (src_read),
        .cnt       (in_cnt),
        .last      (in_last)
    );

    // The core only writes when full_n is high, so a result counts on the gated write alone.
    conv1d_beat_gate #(.LIMIT(NOUT), .COUNT_ON_VLD(1'b1)) u_out_gate (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .en        (out_en),
        .clr       (core_rst),
        .up_vld    (core_out_write),
        .dn_rdy    (dst_full_n),
        .gated_vld (dst_write),
        .gated_rdy (core_out_full_n),
        .accept    (unused_out_acc),
        .cnt       (out_cnt),
        .last      (unused_out_last)
    );

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (ap_start) state_nxt = ST_CLEAR;
            ST_CLEAR: if (clr_cnt == CLR_W'(CLEAR_CYCLES - 1)) state_nxt = ST_RUN;
            ST_RUN:   if (in_last) state_nxt = ST_DRAIN;
            ST_DRAIN: if (out_cnt == OUT_W'(NOUT)) state_nxt = ST_DONE;
            ST_DONE:  if (ap_continue) state_nxt = ap_start ? ST_CLEAR : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Moore outputs, decoded from the state flops only
    always_comb begin
        ap_idle  = 1'b0;
        ap_done  = 1'b0;
        core_rst = 1'b0;
        in_en    = 1'b0;
        out_en   = 1'b0;
        case (state)
            ST_IDLE:  begin ap_idle = 1'b1; core_rst = 1'b1; end
            ST_CLEAR: core_rst = 1'b1;
            ST_RUN:   begin in_en = 1'b1; out_en = 1'b1; end
            ST_DRAIN: out_en = 1'b1;
            ST_DONE:  ap_done = 1'b1;
            default:  ap_idle = 1'b1;
        endcase
    end

    assign start_frame = (state_nxt == ST_CLEAR) && (state != ST_CLEAR);
    assign drop_beat   = core_out_write && !dst_write;

    // clr_cnt is zero on CLEAR entry and counts the cycles spent there.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end else begin
            clr_cnt <= '0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            frame_cnt <= '0;
        end else if (ap_done && ap_continue) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // A dropped write wins over the clear, so an error in the launch cycle is not lost.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            err_overflow <= 1'b0;
        end else if (drop_beat) begin
            err_overflow <= 1'b1;
        end else if (start_frame) begin
            err_overflow <= 1'b0;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{unused_in_rdy, unused_out_acc, unused_out_last, in_cnt};

endmodule

// File: tb/tb_conv1d_frame_ctrl.sv
module tb_conv1d_frame_ctrl;

    localparam int DW   = 8;
    localparam int NIN  = 128;
    localparam int NOUT = 97;
    localparam int K    = NIN - NOUT + 1;
    localparam int CLR  = 2;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          ap_start = 1'b0;
    logic          ap_continue = 1'b0;
    logic          ap_done, ap_idle, ap_ready;
    logic [DW-1:0] src_dout = '0;
    logic          src_empty_n = 1'b0;
    logic          src_read;
    logic [DW-1:0] core_in_dout;
    logic          core_in_empty_n;
    logic          core_in_read = 1'b0;
    logic [DW-1:0] core_out_din = '0;
    logic          core_out_write = 1'b0;
    logic          core_out_full_n;
    logic [DW-1:0] dst_din;
    logic          dst_write;
    logic          dst_full_n = 1'b1;
    logic          core_rst;
    logic          err_overflow;
    logic [15:0]   frame_cnt;

    conv1d_frame_ctrl #(.DATA_W(DW), .NIN(NIN), .NOUT(NOUT), .CLEAR_CYCLES(CLR)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_continue(ap_continue),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .src_dout(src_dout), .src_empty_n(src_empty_n), .src_read(src_read),
        .core_in_dout(core_in_dout), .core_in_empty_n(core_in_empty_n), .core_in_read(core_in_read),
        .core_out_din(core_out_din), .core_out_write(core_out_write), .core_out_full_n(core_out_full_n),
        .dst_din(dst_din), .dst_write(dst_write), .dst_full_n(dst_full_n),
        .core_rst(core_rst), .err_overflow(err_overflow), .frame_cnt(frame_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // stimulus knobs
    bit knob_src_rand, knob_dst_toggle, knob_ovf;
    bit start_lvl, cont_lvl;
    int stop_after_done;

    // core behavioural model: one result per input once the kernel window is full
    int core_got, core_sent;

    // observed statistics
    int cyc, n_read, n_write, n_ready, ready_idx, n_done_cyc, n_frames_acked;
    int viol_full, viol_clr_read, pass_err, first_read_cyc, n_cwr, rst_run;
    int rst_runs[$];
    int exp_frames;

    task automatic clear_stats();
        n_read = 0; n_write = 0; n_ready = 0; ready_idx = -1; n_done_cyc = 0;
        n_frames_acked = 0; viol_full = 0; viol_clr_read = 0; pass_err = 0;
        first_read_cyc = -1; n_cwr = 0; rst_run = 0; rst_runs.delete();
    endtask

    task automatic step();
        int avail;
        @(posedge ap_clk);
        #1;
        cyc++;
        if (core_rst) begin core_got = 0; core_sent = 0; end
        src_dout     = DW'($urandom);
        core_out_din = DW'($urandom);
        src_empty_n  = knob_src_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        dst_full_n   = knob_dst_toggle ? ~dst_full_n : 1'b1;
        core_in_read = 1'b1;
        ap_continue  = cont_lvl;
        ap_start     = start_lvl;
        if (stop_after_done > 0 && ap_done && (n_frames_acked + 1 >= stop_after_done))
            ap_start = 1'b0;
        avail = (core_got >= K) ? core_got - K + 1 : 0;
        if (knob_ovf && core_got == NIN) avail = avail + 1;
        #1;
        core_out_write = (core_sent < avail) && (core_out_full_n || core_sent >= NOUT);
        @(negedge ap_clk);
        if (src_read) begin
            n_read++; core_got++;
            if (first_read_cyc < 0) first_read_cyc = cyc;
        end
        if (ap_ready) begin n_ready++; ready_idx = n_read; end
        if (dst_write) n_write++;
        if (dst_write && !dst_full_n) viol_full++;
        if (src_read && core_rst) viol_clr_read++;
        if (core_in_dout !== src_dout || dst_din !== core_out_din) pass_err++;
        if (core_out_write) begin core_sent++; n_cwr++; end
        if (ap_done) n_done_cyc++;
        if (ap_done && ap_continue) n_frames_acked++;
        if (core_rst) rst_run++;
        else if (rst_run > 0) begin rst_runs.push_back(rst_run); rst_run = 0; end
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        ap_start = 1'b0; ap_continue = 1'b0; start_lvl = 0; cont_lvl = 0;
        knob_src_rand = 0; knob_dst_toggle = 0; knob_ovf = 0; stop_after_done = 0;
        core_out_write = 1'b0;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        core_got = 0; core_sent = 0; exp_frames = 0;
    endtask

    task automatic run_to_done();
        for (int i = 0; i < 3000 && n_done_cyc == 0; i++) step();
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        src_empty_n = 1'b1; core_in_read = 1'b1; core_out_write = 1'b1; dst_full_n = 1'b1;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        n_checks++; if (ap_idle !== 1'b1) $display("FAIL rst_idle: got %b want 1", ap_idle); else n_pass++;
        n_checks++; if (ap_done !== 1'b0) $display("FAIL rst_done: got %b want 0", ap_done); else n_pass++;
        n_checks++; if (ap_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", ap_ready); else n_pass++;
        n_checks++; if (core_rst !== 1'b1) $display("FAIL rst_core_rst: got %b want 1", core_rst); else n_pass++;
        n_checks++; if (src_read !== 1'b0) $display("FAIL rst_src_read: got %b want 0", src_read); else n_pass++;
        n_checks++; if (dst_write !== 1'b0) $display("FAIL rst_dst_write: got %b want 0", dst_write); else n_pass++;
        n_checks++; if (err_overflow !== 1'b0) $display("FAIL rst_err: got %b want 0", err_overflow); else n_pass++;
        n_checks++; if (frame_cnt !== 16'd0) $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); else n_pass++;
        do_reset();
    endtask

    task automatic test_single_frame();
        int start_cyc;
        clear_stats();
        cont_lvl = 1; start_lvl = 1;
        step();
        start_cyc = cyc;
        start_lvl = 0;
        run_to_done();
        step(); step();
        exp_frames++;
        n_checks++; if (n_read !== NIN) $display("FAIL single_reads: got %0d want %0d", n_read, NIN); else n_pass++;
        n_checks++; if (n_write !== NOUT) $display("FAIL single_writes: got %0d want %0d", n_write, NOUT); else n_pass++;
        n_checks++; if (n_ready !== 1) $display("FAIL single_ready_pulses: got %0d want 1", n_ready); else n_pass++;
        n_checks++; if (ready_idx !== NIN) $display("FAIL single_ready_pos: got %0d want %0d", ready_idx, NIN); else n_pass++;
        n_checks++; if (n_done_cyc !== 1) $display("FAIL single_done_cycles: got %0d want 1", n_done_cyc); else n_pass++;
        n_checks++; if (first_read_cyc - start_cyc !== CLR + 1)
            $display("FAIL start_latency: got %0d want %0d", first_read_cyc - start_cyc, CLR + 1); else n_pass++;
        n_checks++; if (frame_cnt !== 16'(exp_frames)) $display("FAIL single_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); else n_pass++;
        n_checks++; if (ap_idle !== 1'b1) $display("FAIL single_idle_after: got %b want 1", ap_idle); else n_pass++;
        n_checks++; if (pass_err !== 0) $display("FAIL single_passthrough: got %0d want 0", pass_err); else n_pass++;
        n_checks++; if (err_overflow !== 1'b0) $display("FAIL single_err: got %b want 0", err_overflow); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_stats();
        start_lvl = 1; cont_lvl = 1; stop_after_done = 3;
        for (int i = 0; i < 3000 && n_frames_acked < 3; i++) step();
        start_lvl = 0; stop_after_done = 0;
        repeat (3) step();
        exp_frames = 3;
        n_checks++; if (rst_runs.size() < 3 || rst_runs[1] !== CLR)
            $display("FAIL b2b_gap1: got %0d runs, gap %0d want %0d", rst_runs.size(), (rst_runs.size() > 1) ? rst_runs[1] : -1, CLR); else n_pass++;
        n_checks++; if (rst_runs.size() < 3 || rst_runs[2] !== CLR)
            $display("FAIL b2b_gap2: got %0d runs, gap %0d want %0d", rst_runs.size(), (rst_runs.size() > 2) ? rst_runs[2] : -1, CLR); else n_pass++;
        n_checks++; if (n_read !== 3 * NIN) $display("FAIL b2b_reads: got %0d want %0d", n_read, 3 * NIN); else n_pass++;
        n_checks++; if (n_write !== 3 * NOUT) $display("FAIL b2b_writes: got %0d want %0d", n_write, 3 * NOUT); else n_pass++;
        n_checks++; if (n_ready !== 3) $display("FAIL b2b_ready: got %0d want 3", n_ready); else n_pass++;
        n_checks++; if (viol_clr_read !== 0) $display("FAIL b2b_read_in_clear: got %0d want 0", viol_clr_read); else n_pass++;
        n_checks++; if (frame_cnt !== 16'(exp_frames)) $display("FAIL b2b_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); else n_pass++;
    endtask

    task automatic test_backpressure();
        clear_stats();
        knob_src_rand = 1; knob_dst_toggle = 1; cont_lvl = 1;
        start_lvl = 1; step(); start_lvl = 0;
        run_to_done();
        step(); step();
        knob_src_rand = 0; knob_dst_toggle = 0;
        exp_frames++;
        n_checks++; if (n_read !== NIN) $display("FAIL bp_reads: got %0d want %0d", n_read, NIN); else n_pass++;
        n_checks++; if (n_write !== NOUT) $display("FAIL bp_writes: got %0d want %0d", n_write, NOUT); else n_pass++;
        n_checks++; if (viol_full !== 0) $display("FAIL bp_write_when_full: got %0d want 0", viol_full); else n_pass++;
        n_checks++; if (pass_err !== 0) $display("FAIL bp_passthrough: got %0d want 0", pass_err); else n_pass++;
        n_checks++; if (frame_cnt !== 16'(exp_frames)) $display("FAIL bp_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); else n_pass++;
    endtask

    task automatic test_continue_hold();
        clear_stats();
        cont_lvl = 0;
        start_lvl = 1; step(); start_lvl = 0;
        run_to_done();
        repeat (9) step();
        n_checks++; if (n_done_cyc !== 10) $display("FAIL hold_done_cycles: got %0d want 10", n_done_cyc); else n_pass++;
        n_checks++; if (ap_done !== 1'b1) $display("FAIL hold_done_level: got %b want 1", ap_done); else n_pass++;
        n_checks++; if (frame_cnt !== 16'(exp_frames)) $display("FAIL hold_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); else n_pass++;
        cont_lvl = 1; step();
        cont_lvl = 0; step();
        exp_frames++;
        n_checks++; if (frame_cnt !== 16'(exp_frames)) $display("FAIL cont_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); else n_pass++;
        n_checks++; if (ap_done !== 1'b0) $display("FAIL cont_done: got %b want 0", ap_done); else n_pass++;
        n_checks++; if (ap_idle !== 1'b1) $display("FAIL cont_idle: got %b want 1", ap_idle); else n_pass++;
        n_checks++; if (n_done_cyc !== 11) $display("FAIL cont_done_total: got %0d want 11", n_done_cyc); else n_pass++;
    endtask

    task automatic test_overflow();
        clear_stats();
        knob_ovf = 1; cont_lvl = 1;
        start_lvl = 1; step(); start_lvl = 0;
        run_to_done();
        step(); step();
        knob_ovf = 0;
        exp_frames++;
        n_checks++; if (n_cwr !== NOUT + 1) $display("FAIL ovf_core_writes: got %0d want %0d", n_cwr, NOUT + 1); else n_pass++;
        n_checks++; if (n_write !== NOUT) $display("FAIL ovf_forwarded: got %0d want %0d", n_write, NOUT); else n_pass++;
        n_checks++; if (err_overflow !== 1'b1) $display("FAIL ovf_err_set: got %b want 1", err_overflow); else n_pass++;
        repeat (5) step();
        n_checks++; if (err_overflow !== 1'b1) $display("FAIL ovf_err_sticky: got %b want 1", err_overflow); else n_pass++;
        clear_stats();
        start_lvl = 1; step(); start_lvl = 0;
        step();
        n_checks++; if (err_overflow !== 1'b0) $display("FAIL ovf_err_cleared: got %b want 0", err_overflow); else n_pass++;
        run_to_done();
        step(); step();
        exp_frames++;
        n_checks++; if (err_overflow !== 1'b0) $display("FAIL ovf_err_clean_frame: got %b want 0", err_overflow); else n_pass++;
        n_checks++; if (frame_cnt !== 16'(exp_frames)) $display("FAIL ovf_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        clear_stats();
        cont_lvl = 1;
        start_lvl = 1; step(); start_lvl = 0;
        for (int i = 0; i < 500 && n_read < 50; i++) step();
        n_checks++; if (n_read !== 50) $display("FAIL mid_reads_before_reset: got %0d want 50", n_read); else n_pass++;
        ap_rst_n = 1'b0;
        #1;
        n_checks++; if (ap_idle !== 1'b1) $display("FAIL mid_idle: got %b want 1", ap_idle); else n_pass++;
        n_checks++; if (core_rst !== 1'b1) $display("FAIL mid_core_rst: got %b want 1", core_rst); else n_pass++;
        n_checks++; if (ap_done !== 1'b0) $display("FAIL mid_done: got %b want 0", ap_done); else n_pass++;
        n_checks++; if (src_read !== 1'b0) $display("FAIL mid_src_read: got %b want 0", src_read); else n_pass++;
        n_checks++; if (frame_cnt !== 16'd0) $display("FAIL mid_frame_cnt: got %0d want 0", frame_cnt); else n_pass++;
        core_out_write = 1'b0;
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        core_got = 0; core_sent = 0; exp_frames = 0;
        clear_stats();
        start_lvl = 1; step(); start_lvl = 0;
        run_to_done();
        step(); step();
        exp_frames++;
        n_checks++; if (n_read !== NIN) $display("FAIL mid_next_reads: got %0d want %0d", n_read, NIN); else n_pass++;
        n_checks++; if (n_write !== NOUT) $display("FAIL mid_next_writes: got %0d want %0d", n_write, NOUT); else n_pass++;
        n_checks++; if (n_ready !== 1) $display("FAIL mid_next_ready: got %0d want 1", n_ready); else n_pass++;
        n_checks++; if (frame_cnt !== 16'(exp_frames)) $display("FAIL mid_next_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); else n_pass++;
    endtask

    initial begin
        cyc = 0; core_got = 0; core_sent = 0; exp_frames = 0;
        knob_src_rand = 0; knob_dst_toggle = 0; knob_ovf = 0;
        start_lvl = 0; cont_lvl = 0; stop_after_done = 0;
        clear_stats();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_continue_hold();
        test_overflow();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
